// File: rtl/frame_detector_top.sv
// Framed-packet receiver and 8-channel serial router: parses header/channel/payload/CRC/trailer,
// checks CRC-16/XMODEM and serializes good frames MSB first. Define GRAY_CODE_EN to Gray-code payloads.
module frame_detector_top #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] HEADER     = 32'hE0E0E0E0,
  parameter logic [31:0] TRAILER    = 32'h0E0E0E0E
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  output logic        data_out_ch1,
  output logic        data_out_ch2,
  output logic        data_out_ch3,
  output logic        data_out_ch4,
  output logic        data_out_ch5,
  output logic        data_out_ch6,
  output logic        data_out_ch7,
  output logic        data_out_ch8,
  output logic        data_vld_ch1,
  output logic        data_vld_ch2,
  output logic        data_vld_ch3,
  output logic        data_vld_ch4,
  output logic        data_vld_ch5,
  output logic        data_vld_ch6,
  output logic        data_vld_ch7,
  output logic        data_vld_ch8,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic        crc_valid_o,
  output logic        crc_err
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int ENTRY_W = 3 + 3 + 128;

  localparam logic [15:0] HDR_HI = HEADER[31:16];
  localparam logic [15:0] HDR_LO = HEADER[15:0];
  localparam logic [15:0] TRL_HI = TRAILER[31:16];
  localparam logic [15:0] TRL_LO = TRAILER[15:0];

  typedef enum logic [2:0] {P_IDLE, P_HDR, P_CHAN, P_COLLECT, P_TRL} p_state_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} s_state_t;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      if (r[15] ^ w[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // ---------------- parser ----------------
  p_state_t     p_state, p_next;
  logic [3:0]   cnt;
  logic [2:0]   chan_idx, chan_enc;
  logic [143:0] word_buf;
  logic [15:0]  crc_all, crc_excl, crc_mid, crc_one, push_word;
  logic         chan_ok, do_clear, push_one, push_two, frame_end;
  logic         frame_good, frame_bad;
  logic [127:0] payload_raw, payload_enc;

  assign chan_ok = (data_in[15:8] == 8'h00) && $onehot(data_in[7:0]);

  always_comb begin
    chan_enc = 3'd0;
    for (int i = 0; i < 8; i++) if (data_in[i]) chan_enc = 3'(i);
  end

  always_comb begin
    p_next    = p_state;
    do_clear  = 1'b0;
    push_one  = 1'b0;
    push_two  = 1'b0;
    push_word = data_in;
    frame_end = 1'b0;
    case (p_state)
      P_IDLE:  if (data_in == HDR_HI) p_next = P_HDR;
      P_HDR: begin
        if (data_in == HDR_LO)      p_next = P_CHAN;
        else if (data_in != HDR_HI) p_next = P_IDLE;
      end
      P_CHAN: begin
        if (chan_ok) begin
          p_next   = P_COLLECT;
          do_clear = 1'b1;
        end else begin
          p_next = P_IDLE;
        end
      end
      P_COLLECT: begin
        if (data_in == TRL_HI)  p_next = P_TRL;
        else if (cnt == 4'd9)   p_next = P_IDLE;
        else                    push_one = 1'b1;
      end
      P_TRL: begin
        // A lone first-trailer word turns out to be payload: buffer it after the fact.
        if (data_in == TRL_LO) begin
          p_next    = P_IDLE;
          frame_end = 1'b1;
        end else if (data_in == TRL_HI) begin
          push_word = TRL_HI;
          if (cnt == 4'd9) p_next = P_IDLE;
          else             push_one = 1'b1;
        end else if (cnt >= 4'd8) begin
          p_next = P_IDLE;
        end else begin
          push_two = 1'b1;
          p_next   = P_COLLECT;
        end
      end
      default: p_next = P_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) p_state <= P_IDLE;
    else        p_state <= p_next;
  end

  assign crc_one = crc_upd(crc_all, push_word);
  assign crc_mid = crc_upd(crc_all, TRL_HI);

  // crc_excl tracks the CRC of every buffered word except the newest, which is the CRC candidate.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      word_buf <= '0;
      cnt      <= '0;
      chan_idx <= '0;
      crc_all  <= '0;
      crc_excl <= '0;
    end else if (do_clear) begin
      word_buf <= '0;
      cnt      <= '0;
      chan_idx <= chan_enc;
      crc_all  <= '0;
      crc_excl <= '0;
    end else if (push_one) begin
      word_buf <= {word_buf[127:0], push_word};
      cnt      <= cnt + 4'd1;
      crc_excl <= crc_all;
      crc_all  <= crc_one;
    end else if (push_two) begin
      word_buf <= {word_buf[111:0], TRL_HI, data_in};
      cnt      <= cnt + 4'd2;
      crc_excl <= crc_mid;
      crc_all  <= crc_upd(crc_mid, data_in);
    end
  end

  assign frame_good  = frame_end && (cnt >= 4'd2) && (crc_excl == word_buf[15:0]);
  assign frame_bad   = frame_end && (cnt >= 4'd2) && (crc_excl != word_buf[15:0]);
  assign payload_raw = word_buf[143:16];

`ifdef GRAY_CODE_EN
  assign payload_enc = payload_raw ^ (payload_raw >> 1);
`else
  assign payload_enc = payload_raw;
`endif

  // Handshake: frame_wr is a one-cycle valid with no ready; the FIFO accepts when not full
  // and otherwise the frame is silently dropped. fifo_rd pops only when the FIFO is non-empty.
  logic               frame_wr;
  logic [ENTRY_W-1:0] frame_entry;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      frame_wr    <= 1'b0;
      crc_err     <= 1'b0;
      frame_entry <= '0;
    end else begin
      frame_wr <= frame_good;
      crc_err  <= frame_bad;
      if (frame_good) frame_entry <= {chan_idx, 3'(cnt - 4'd2), payload_enc};
    end
  end

  // ---------------- frame FIFO ----------------
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      fifo_count, count_next;
  logic               fifo_wr, fifo_rd;
  logic [ENTRY_W-1:0] rd_entry;

  assign fifo_wr    = frame_wr && !fifo_full;
  assign count_next = fifo_count + CW'(fifo_wr) - CW'(fifo_rd);
  assign rd_entry   = fifo_mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= frame_entry;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_next;
      fifo_full  <= (count_next == CW'(FIFO_DEPTH));
      fifo_empty <= (count_next == '0);
    end
  end

  // ---------------- serializer ----------------
  s_state_t     s_state, s_next;
  logic [2:0]   s_chan;
  logic [127:0] s_payload;
  logic [6:0]   bit_idx, bit_idx_m1;
  logic [7:0]   chan_mask, out_data, out_vld;

  assign bit_idx_m1 = bit_idx - 7'd1;
  assign chan_mask  = 8'd1 << s_chan;

  always_comb begin
    s_next  = s_state;
    fifo_rd = 1'b0;
    case (s_state)
      S_IDLE: begin
        if (!fifo_empty) begin
          s_next  = S_LOAD;
          fifo_rd = 1'b1;
        end
      end
      S_LOAD:  s_next = S_SHIFT;
      S_SHIFT: if (bit_idx == 7'd0) s_next = S_IDLE;
      default: s_next = S_IDLE;
    endcase
  end

  // bit_idx starts at 16N-1; the final shift cycle clears the outputs, giving the inter-frame gap.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s_state     <= S_IDLE;
      s_chan      <= '0;
      s_payload   <= '0;
      bit_idx     <= '0;
      out_data    <= '0;
      out_vld     <= '0;
      crc_valid_o <= 1'b0;
    end else begin
      s_state <= s_next;
      case (s_state)
        S_IDLE: begin
          if (fifo_rd) begin
            s_chan    <= rd_entry[133:131];
            bit_idx   <= {rd_entry[130:128], 4'hF};
            s_payload <= rd_entry[127:0];
          end
        end
        S_LOAD: begin
          out_vld     <= chan_mask;
          out_data    <= s_payload[bit_idx] ? chan_mask : 8'h00;
          crc_valid_o <= 1'b1;
        end
        S_SHIFT: begin
          if (bit_idx == 7'd0) begin
            out_vld     <= '0;
            out_data    <= '0;
            crc_valid_o <= 1'b0;
          end else begin
            bit_idx  <= bit_idx_m1;
            out_data <= s_payload[bit_idx_m1] ? chan_mask : 8'h00;
          end
        end
        default: ;
      endcase
    end
  end

  assign {data_out_ch8, data_out_ch7, data_out_ch6, data_out_ch5,
          data_out_ch4, data_out_ch3, data_out_ch2, data_out_ch1} = out_data;
  assign {data_vld_ch8, data_vld_ch7, data_vld_ch6, data_vld_ch5,
          data_vld_ch4, data_vld_ch3, data_vld_ch2, data_vld_ch1} = out_vld;

endmodule

// File: tb/tb_frame_detector_top.sv
// Directed bench for frame_detector_top: frames are driven word by word, serial output is
// collected per frame and compared with hand-derived expected frames.
module tb_frame_detector_top;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic        data_out_ch1, data_out_ch2, data_out_ch3, data_out_ch4;
  logic        data_out_ch5, data_out_ch6, data_out_ch7, data_out_ch8;
  logic        data_vld_ch1, data_vld_ch2, data_vld_ch3, data_vld_ch4;
  logic        data_vld_ch5, data_vld_ch6, data_vld_ch7, data_vld_ch8;
  logic        fifo_empty, fifo_full, crc_valid_o, crc_err;

  frame_detector_top dut (
    .clk_in(clk_in), .rst_n(rst_n), .data_in(data_in),
    .data_out_ch1(data_out_ch1), .data_out_ch2(data_out_ch2),
    .data_out_ch3(data_out_ch3), .data_out_ch4(data_out_ch4),
    .data_out_ch5(data_out_ch5), .data_out_ch6(data_out_ch6),
    .data_out_ch7(data_out_ch7), .data_out_ch8(data_out_ch8),
    .data_vld_ch1(data_vld_ch1), .data_vld_ch2(data_vld_ch2),
    .data_vld_ch3(data_vld_ch3), .data_vld_ch4(data_vld_ch4),
    .data_vld_ch5(data_vld_ch5), .data_vld_ch6(data_vld_ch6),
    .data_vld_ch7(data_vld_ch7), .data_vld_ch8(data_vld_ch8),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .crc_valid_o(crc_valid_o), .crc_err(crc_err)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  int tests = 0;
  int failures = 0;
  int err_pulses = 0;
  int viol = 0;

  logic [139:0] cap_q[$];
  logic [139:0] exp_q[$];

`ifdef GRAY_CODE_EN
  localparam logic [15:0] EXP_A55A     = 16'hF7F7;
  localparam logic [31:0] EXP_1111A55A = 32'h199977F7;
  localparam logic [15:0] EXP_BEEF     = 16'hE198;
`else
  localparam logic [15:0] EXP_A55A     = 16'hA55A;
  localparam logic [31:0] EXP_1111A55A = 32'h1111A55A;
  localparam logic [15:0] EXP_BEEF     = 16'hBEEF;
`endif

  function automatic logic [127:0] enc(input logic [127:0] x);
`ifdef GRAY_CODE_EN
    return x ^ (x >> 1);
`else
    return x;
`endif
  endfunction

  function automatic logic [15:0] crc_ref(input logic [127:0] v);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = 127; i >= 0; i--) begin
      fb = c[15] ^ v[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic logic [139:0] pack(input int ch, input int len, input logic [127:0] v);
    return {4'(ch), 8'(len), v};
  endfunction

  // ---------------- collector: one entry per serialized frame ----------------
  logic [7:0]   mv, md;
  logic [3:0]   cap_ch = '0, cur_ch;
  logic [7:0]   cap_len = '0;
  logic [127:0] cap_val = '0;

  always @(negedge clk_in) begin
    mv = {data_vld_ch8, data_vld_ch7, data_vld_ch6, data_vld_ch5,
          data_vld_ch4, data_vld_ch3, data_vld_ch2, data_vld_ch1};
    md = {data_out_ch8, data_out_ch7, data_out_ch6, data_out_ch5,
          data_out_ch4, data_out_ch3, data_out_ch2, data_out_ch1};
    if (rst_n === 1'b1) begin
      if (crc_err === 1'b1) err_pulses++;
      if (crc_valid_o !== (|mv)) viol++;
      if (!$onehot0(mv)) viol++;
      if ((md & ~mv) != 8'h00) viol++;
      if (|mv) begin
        cur_ch = 4'd0;
        for (int i = 0; i < 8; i++) if (mv[i]) cur_ch = 4'(i + 1);
        if (cap_len != 0 && cur_ch != cap_ch) viol++;
        cap_ch  = cur_ch;
        cap_val = {cap_val[126:0], |(md & mv)};
        cap_len = cap_len + 8'd1;
      end else if (cap_len != 0) begin
        cap_q.push_back({cap_ch, cap_len, cap_val});
        cap_len = '0;
        cap_val = '0;
      end
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [139:0] obs, input logic [139:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    @(negedge clk_in);
    data_in = w;
  endtask

  task automatic send_frame(input logic [15:0] chan_word, input int n, input logic [127:0] p,
                            input logic bad, input logic [15:0] bad_crc);
    send_word(16'hE0E0);
    send_word(16'hE0E0);
    send_word(chan_word);
    for (int k = n - 1; k >= 0; k--) send_word(p[16*k +: 16]);
    send_word(bad ? bad_crc : crc_ref(p));
    send_word(16'h0E0E);
    send_word(16'h0E0E);
  endtask

  task automatic check_frames(input int n, input string tag);
    int cyc;
    logic [139:0] got;
    cyc = 0;
    while (cap_q.size() < n && cyc < 3000) begin
      @(negedge clk_in);
      cyc++;
    end
    check({tag, "_count"}, 140'(cap_q.size() >= n), 140'(1));
    for (int k = 0; k < n; k++) begin
      got = (cap_q.size() > 0) ? cap_q.pop_front() : '0;
      check({tag, "_frame"}, got, (exp_q.size() > 0) ? exp_q.pop_front() : '1);
    end
  endtask

  logic [127:0] big, bp;

  initial begin
    // ---------------- reset ----------------
    rst_n   = 1'b0;
    data_in = 16'h0000;
    repeat (3) @(negedge clk_in);
    check("rst_vld", 140'({data_vld_ch8, data_vld_ch7, data_vld_ch6, data_vld_ch5,
                           data_vld_ch4, data_vld_ch3, data_vld_ch2, data_vld_ch1}), 140'(0));
    check("rst_data", 140'({data_out_ch8, data_out_ch7, data_out_ch6, data_out_ch5,
                            data_out_ch4, data_out_ch3, data_out_ch2, data_out_ch1}), 140'(0));
    check("rst_fifo_empty", 140'(fifo_empty), 140'(1));
    check("rst_fifo_full", 140'(fifo_full), 140'(0));
    check("rst_crc_valid", 140'(crc_valid_o), 140'(0));
    check("rst_crc_err", 140'(crc_err), 140'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // ---------------- ch1, 16-bit payload, latency ----------------
    send_frame(16'h0001, 1, 128'hA55A, 1'b0, 16'h0);
    @(negedge clk_in); data_in = 16'h0000;
    check("t1_no_crc_err", 140'(crc_err), 140'(0));
    @(negedge clk_in);
    check("t1_fifo_nonempty", 140'(fifo_empty), 140'(0));
    @(negedge clk_in);
    check("t1_vld_early", 140'(data_vld_ch1), 140'(0));
    @(negedge clk_in);
    check("t1_vld_first", 140'(data_vld_ch1), 140'(1));
    check("t1_msb", 140'(data_out_ch1), 140'(EXP_A55A[15]));
    exp_q.push_back(pack(1, 16, 128'(EXP_A55A)));
    check_frames(1, "t1");

    // ---------------- ch1, 32-bit payload ----------------
    send_frame(16'h0001, 2, 128'h1111A55A, 1'b0, 16'h0);
    send_word(16'h0000);
    exp_q.push_back(pack(1, 32, 128'(EXP_1111A55A)));
    check_frames(1, "t2");
    check("t2_no_err", 140'(err_pulses), 140'(0));

    // ---------------- ch2, 128-bit payload ----------------
    big = 128'h0123456789ABCDEFFEDCBA9876543210;
    send_frame(16'h0002, 8, big, 1'b0, 16'h0);
    send_word(16'h0000);
    exp_q.push_back(pack(2, 128, enc(big)));
    check_frames(1, "t3");

    // ---------------- bad CRC ----------------
    send_frame(16'h0001, 1, 128'h1234, 1'b1, 16'hFFFF);
    @(negedge clk_in); data_in = 16'h0000;
    check("t4_err_pulse", 140'(crc_err), 140'(1));
    @(negedge clk_in);
    check("t4_err_single", 140'(crc_err), 140'(0));
    check("t4_fifo_empty", 140'(fifo_empty), 140'(1));
    repeat (10) @(negedge clk_in);
    check("t4_no_output", 140'(cap_q.size()), 140'(0));
    check("t4_err_count", 140'(err_pulses), 140'(1));

    // ---------------- FIFO overflow: first frame drains, next four fill, sixth dropped ----------------
    for (int i = 0; i < 6; i++) begin
      bp = big ^ {8{16'(i * 16'h1111)}};
      send_frame(16'(1 << i), 8, bp, 1'b0, 16'h0);
      if (i < 5) exp_q.push_back(pack(i + 1, 128, enc(bp)));
    end
    send_word(16'h0000);
    repeat (2) @(negedge clk_in);
    check("t5_fifo_full", 140'(fifo_full), 140'(1));
    check_frames(5, "t5");
    repeat (200) @(negedge clk_in);
    check("t5_dropped", 140'(cap_q.size()), 140'(0));
    check("t5_fifo_empty", 140'(fifo_empty), 140'(1));
    check("t5_fifo_not_full", 140'(fifo_full), 140'(0));

    // ---------------- corrupt stimulus, then a valid frame ----------------
    send_word(16'hE0E0);
    send_word(16'hE0E0);
    send_word(16'h0003);
    for (int k = 0; k < 10; k++) send_word(16'(16'h1000 + k));
    send_word(16'hE0E0);
    send_word(16'hE0E0);
    send_word(16'h0008);
    for (int k = 0; k < 10; k++) send_word(16'(16'h2000 + k));
    send_frame(16'h0080, 1, 128'hBEEF, 1'b0, 16'h0);
    send_word(16'h0000);
    exp_q.push_back(pack(8, 16, 128'(EXP_BEEF)));
    check_frames(1, "t6");
    check("t6_no_err", 140'(err_pulses), 140'(1));

    repeat (5) @(negedge clk_in);
    check("output_protocol", 140'(viol), 140'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
